// File: rtl/scroll_sequencer.sv
// scroll_sequencer: moves whole rows of the text cell RAM inside a
// scrolling region one cell per cycle and blanks the vacated rows.
// A one-entry pending slot holds a request that arrives mid-scroll.
module scroll_sequencer #(
    parameter int LINES   = 30,
    parameter int COLUMNS = 80,
    parameter int CELL_W  = 16,
    parameter logic [CELL_W-1:0] BLANK = 16'h0020
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_dir,
    input  logic [7:0]        req_step,
    input  logic [7:0]        req_top,
    input  logic [7:0]        req_bottom,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [7:0]        rd_row,
    output logic [7:0]        rd_col,
    input  logic [CELL_W-1:0] rd_data,
    output logic              wr_en,
    output logic [7:0]        wr_row,
    output logic [7:0]        wr_col,
    output logic [CELL_W-1:0] wr_data
);

    localparam logic [7:0] LINES_B   = 8'(LINES);
    localparam logic [7:0] COPY_LAST = 8'(COLUMNS);
    localparam logic [7:0] CLR_LAST  = 8'(COLUMNS - 1);

    typedef enum logic [1:0] {IDLE, COPY, CLEAR, DONE} state_t;

    state_t     state, next_state;
    logic [7:0] col, row;
    logic       a_dir;
    logic [7:0] a_top, a_bottom, a_n;
    logic       p_full, p_dir;
    logic [7:0] p_top, p_bottom, p_step;
    logic       ready_en;

    logic       accept, launch, advance, use_pend, p_load;
    logic       l_dir, l_degen, l_copy;
    logic [7:0] l_top, l_bottom, l_step, l_h, l_n, l_row;
    logic       row_end, last_row, n_copy;
    logic [7:0] nrow, src;

    // A row is copied when its source row still lies inside the region;
    // sums are taken 9 bits wide so a region near row 255 cannot wrap.
    function automatic logic row_copies(input logic dir, input logic [7:0] r,
                                        input logic [7:0] top, input logic [7:0] bottom,
                                        input logic [7:0] n);
        if (!dir)
            return ({1'b0, r} + {1'b0, n}) <= {1'b0, bottom};
        else
            return {1'b0, r} >= ({1'b0, top} + {1'b0, n});
    endfunction

    // State register; reset aborts any scroll in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Launch decode, row sequencing and next-state selection.
    always_comb begin
        accept   = req_valid && req_ready;
        use_pend = (state == DONE) && p_full;
        p_load   = accept && ((state == COPY) || (state == CLEAR) || use_pend);

        l_dir    = use_pend ? p_dir    : req_dir;
        l_top    = use_pend ? p_top    : req_top;
        l_bottom = use_pend ? p_bottom : req_bottom;
        l_step   = use_pend ? p_step   : req_step;
        l_degen  = (l_step == 8'd0) || (l_top > l_bottom) || (l_bottom >= LINES_B);
        l_h      = l_bottom - l_top + 8'd1;
        l_n      = (l_step < l_h) ? l_step : l_h;
        l_row    = l_dir ? l_bottom : l_top;
        l_copy   = row_copies(l_dir, l_row, l_top, l_bottom, l_n);

        row_end  = ((state == COPY) && (col == COPY_LAST)) ||
                   ((state == CLEAR) && (col == CLR_LAST));
        last_row = a_dir ? (row == a_top) : (row == a_bottom);
        nrow     = a_dir ? row - 8'd1 : row + 8'd1;
        n_copy   = row_copies(a_dir, nrow, a_top, a_bottom, a_n);

        launch     = 1'b0;
        advance    = 1'b0;
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) launch = 1'b1;
            end
            COPY, CLEAR: begin
                if (row_end) begin
                    if (last_row) begin
                        next_state = DONE;
                    end else begin
                        advance    = 1'b1;
                        next_state = n_copy ? COPY : CLEAR;
                    end
                end
            end
            DONE: begin
                if (p_full || accept) launch = 1'b1;
                else                  next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (launch) next_state = l_degen ? DONE : (l_copy ? COPY : CLEAR);
    end

    // Active request, row/column counters and the pending slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
            col      <= '0;
            row      <= '0;
            a_dir    <= 1'b0;
            a_top    <= '0;
            a_bottom <= '0;
            a_n      <= '0;
            p_full   <= 1'b0;
            p_dir    <= 1'b0;
            p_top    <= '0;
            p_bottom <= '0;
            p_step   <= '0;
        end else begin
            ready_en <= 1'b1;
            if (launch) begin
                a_dir    <= l_dir;
                a_top    <= l_top;
                a_bottom <= l_bottom;
                a_n      <= l_n;
                row      <= l_row;
                col      <= '0;
            end else if (advance) begin
                row <= nrow;
                col <= '0;
            end else if ((state == COPY) || (state == CLEAR)) begin
                col <= col + 8'd1;
            end
            if (p_load) begin
                p_full   <= 1'b1;
                p_dir    <= req_dir;
                p_top    <= req_top;
                p_bottom <= req_bottom;
                p_step   <= req_step;
            end else if (use_pend) begin
                p_full <= 1'b0;
            end
        end
    end

    // RAM strobes and status; addresses and data read as zero when idle.
    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        req_ready = ready_en && (!p_full || (state == DONE));
        src       = a_dir ? row - a_n : row + a_n;

        rd_en  = (state == COPY) && (col != COPY_LAST);
        rd_row = rd_en ? src : 8'd0;
        rd_col = rd_en ? col : 8'd0;

        wr_en   = ((state == COPY) && (col != 8'd0)) || (state == CLEAR);
        wr_row  = '0;
        wr_col  = '0;
        wr_data = '0;
        if (wr_en) begin
            wr_row  = row;
            wr_col  = (state == COPY) ? col - 8'd1 : col;
            wr_data = (state == COPY) ? rd_data : BLANK;
        end
    end

endmodule

// File: tb/tb_scroll_sequencer.sv
// tb_scroll_sequencer: directed scroll requests against a cell RAM model;
// a forked monitor checks each completed scroll against a queue of
// expected durations and strobe counts.
module tb_scroll_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_dir;
    logic [7:0]  req_step, req_top, req_bottom;
    logic        busy, done, rd_en, wr_en;
    logic [7:0]  rd_row, rd_col, wr_row, wr_col;
    logic [15:0] rd_data, wr_data;

    logic        preload = 1'b0;
    logic [15:0] mem     [30][80];
    logic [15:0] ref_mem [30][80];

    typedef struct {
        int len;
        int wr;
        int rd;
        int top;
        int bottom;
    } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int wr_total = 0;
    int done_total = 0;

    scroll_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
        .req_step(req_step), .req_top(req_top), .req_bottom(req_bottom),
        .busy(busy), .done(done),
        .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    // Cell RAM with one-cycle read latency; preload fills row*256+col.
    always @(posedge clk) begin
        if (preload) begin
            for (int r = 0; r < 30; r++)
                for (int c = 0; c < 80; c++)
                    mem[r][c] <= 16'(r * 256 + c);
        end else if (wr_en && int'(wr_row) < 30 && int'(wr_col) < 80) begin
            mem[int'(wr_row)][int'(wr_col)] <= wr_data;
        end
        if (rd_en && int'(rd_row) < 30 && int'(rd_col) < 80)
            rd_data <= mem[int'(rd_row)][int'(rd_col)];
        else
            rd_data <= 16'h0000;
    end

    task automatic check_output(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Whole-region scroll applied to the reference image from a snapshot.
    task automatic ref_scroll(input bit dir, input int top, input int bottom, input int step);
        logic [15:0] old [30][80];
        int h, n, s;
        if (step == 0 || top > bottom || bottom >= 30) return;
        h = bottom - top + 1;
        n = (step < h) ? step : h;
        old = ref_mem;
        for (int r = top; r <= bottom; r++) begin
            s = dir ? r - n : r + n;
            for (int c = 0; c < 80; c++)
                ref_mem[r][c] = (s >= top && s <= bottom) ? old[s][c] : 16'h0020;
        end
    endtask

    task automatic do_preload();
        @(negedge clk);
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++)
                ref_mem[r][c] = 16'(r * 256 + c);
    endtask

    task automatic apply_stimulus(input bit dir, input int top, input int bottom, input int step,
                                  input int exp_len, input int exp_wr, input int exp_rd,
                                  input bit track, output bit done_at_accept);
        int guard = 0;
        done_at_accept = 1'b0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_dir    = dir;
        req_top    = 8'(top);
        req_bottom = 8'(bottom);
        req_step   = 8'(step);
        while (!req_ready && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            check_output("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        done_at_accept = done;
        if (track) begin
            exp_q.push_back('{exp_len, exp_wr, exp_rd, top, bottom});
            ref_scroll(dir, top, bottom, step);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && guard < 6000) begin
            @(negedge clk);
            guard++;
        end
        check_output("idle_timeout", int'(busy || exp_q.size() != 0), 0);
    endtask

    task automatic compare_mem(input string name);
        int mism = 0;
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++)
                if (mem[r][c] !== ref_mem[r][c]) mism++;
        check_output(name, mism, 0);
    endtask

    // Monitor: per-scroll busy length and strobe counts, checked at done.
    task automatic run_monitor();
        int seg_len = 0, seg_wr = 0, seg_rd = 0, seg_oob = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (wr_en) wr_total++;
            if (!rst_n) begin
                seg_len = 0; seg_wr = 0; seg_rd = 0; seg_oob = 0;
            end else begin
                if (busy) seg_len++;
                if (rd_en) seg_rd++;
                if (wr_en) begin
                    seg_wr++;
                    if (exp_q.size() > 0 &&
                        (int'(wr_row) < exp_q[0].top || int'(wr_row) > exp_q[0].bottom))
                        seg_oob++;
                end
                if ((rd_en || wr_en) && !busy) check_output("strobe_while_idle", 1, 0);
                if (done) begin
                    done_total++;
                    if (exp_q.size() == 0) begin
                        check_output("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("busy_len", seg_len, e.len);
                        check_output("write_count", seg_wr, e.wr);
                        check_output("read_count", seg_rd, e.rd);
                        check_output("writes_outside_region", seg_oob, 0);
                    end
                    seg_len = 0; seg_wr = 0; seg_rd = 0; seg_oob = 0;
                end
            end
        end
    endtask

    initial begin
        bit held;
        int wr_snap, done_snap;
        rst_n = 1'b0;
        req_valid = 1'b0; req_dir = 1'b0;
        req_step = '0; req_top = '0; req_bottom = '0;
        fork
            run_monitor();
        join_none

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_busy", int'(busy), 0);
        check_output("rst_done", int'(done), 0);
        check_output("rst_rd_en", int'(rd_en), 0);
        check_output("rst_wr_en", int'(wr_en), 0);
        check_output("rst_req_ready", int'(req_ready), 0);
        check_output("rst_addr", int'({rd_row, rd_col, wr_row, wr_col}), 0);
        check_output("rst_wr_data", int'(wr_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("ready_after_release", int'(req_ready), 1);

        // full-screen scroll up by one
        do_preload();
        apply_stimulus(1'b0, 0, 29, 1, 2430, 2400, 2320, 1'b1, held);
        #1;
        check_output("busy_after_accept", int'(busy), 1);
        wait_idle();
        compare_mem("mem_up_full");
        check_output("up_row0_col5", int'(mem[0][5]), 16'h0105);
        check_output("up_row28_col79", int'(mem[28][79]), 16'h1D4F);
        check_output("up_row29_blank", int'(mem[29][0]), 16'h0020);

        // region scroll down by two
        do_preload();
        apply_stimulus(1'b1, 5, 9, 2, 404, 400, 240, 1'b1, held);
        wait_idle();
        compare_mem("mem_down_region");
        check_output("down_row9_col3", int'(mem[9][3]), 16'h0703);
        check_output("down_row7_col0", int'(mem[7][0]), 16'h0500);
        check_output("down_row6_blank", int'(mem[6][79]), 16'h0020);
        check_output("down_row4_kept", int'(mem[4][0]), 16'h0400);
        check_output("down_row10_kept", int'(mem[10][0]), 16'h0A00);

        // step clamps to region height, then step zero and inverted bounds
        apply_stimulus(1'b0, 10, 12, 40, 241, 240, 0, 1'b1, held);
        wait_idle();
        compare_mem("mem_clamp");
        check_output("clamp_row11_blank", int'(mem[11][40]), 16'h0020);
        apply_stimulus(1'b0, 3, 8, 0, 1, 0, 0, 1'b1, held);
        wait_idle();
        apply_stimulus(1'b1, 20, 10, 4, 1, 0, 0, 1'b1, held);
        wait_idle();
        apply_stimulus(1'b0, 28, 31, 1, 1, 0, 0, 1'b1, held);
        wait_idle();
        compare_mem("mem_degenerate");

        // three requests back to back through the pending slot
        do_preload();
        apply_stimulus(1'b1, 0, 1, 1, 162, 160, 80, 1'b1, held);
        apply_stimulus(1'b0, 2, 4, 1, 243, 240, 160, 1'b1, held);
        @(negedge clk);
        check_output("ready_drops_slot_full", int'(req_ready), 0);
        apply_stimulus(1'b1, 0, 1, 1, 162, 160, 80, 1'b1, held);
        check_output("third_held_until_done", int'(held), 1);
        check_output("second_no_gap_busy", int'(busy), 1);
        check_output("second_started_done_low", int'(done), 0);
        check_output("ready_low_slot_refilled", int'(req_ready), 0);
        wait_idle();
        compare_mem("mem_back_to_back");

        // reset in the middle of a full-screen scroll
        do_preload();
        apply_stimulus(1'b0, 0, 29, 1, 0, 0, 0, 1'b0, held);
        repeat (99) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_output("abort_busy", int'(busy), 0);
        check_output("abort_wr_en", int'(wr_en), 0);
        check_output("abort_req_ready", int'(req_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wr_snap   = wr_total;
        done_snap = done_total;
        repeat (200) @(negedge clk);
        check_output("abort_no_writes", wr_total - wr_snap, 0);
        check_output("abort_no_done", done_total - done_snap, 0);
        check_output("abort_idle", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
